// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: steps a 1-bit slice LSB-first across WIDTH bits for AND/OR/ADD/SUB/SLT.
// Optional NOR (op=100) is built only when ALU_SERIAL_SEQ_NOR_EN is defined.
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [1:0]       sel
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
`ifdef ALU_SERIAL_SEQ_NOR_EN
    localparam logic [2:0] OP_NOR = 3'b100;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] ash, bsh;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             c, cin_msb, sum_msb;

    logic             bit_b, sum, cout, slice, less;
    logic [WIDTH-1:0] shifted;

    function automatic logic [1:0] sel_of(input logic [2:0] o);
        case (o)
            OP_OR:                  sel_of = 2'b01;
            OP_ADD, OP_SUB, OP_SLT: sel_of = 2'b10;
`ifdef ALU_SERIAL_SEQ_NOR_EN
            OP_NOR:                 sel_of = 2'b01;
`endif
            default:                sel_of = 2'b00;
        endcase
    endfunction

    always_comb begin
        bit_b = bsh[0] ^ op_r[2];
        sum   = ash[0] ^ bit_b ^ c;
        cout  = (ash[0] & bit_b) | (ash[0] & c) | (bit_b & c);
        case (op_r)
            OP_AND:                 slice = ash[0] & bsh[0];
            OP_OR:                  slice = ash[0] | bsh[0];
            OP_ADD, OP_SUB, OP_SLT: slice = sum;
`ifdef ALU_SERIAL_SEQ_NOR_EN
            OP_NOR:                 slice = ~(ash[0] | bsh[0]);
`endif
            default:                slice = 1'b0;
        endcase
        shifted = {slice, result[WIDTH-1:1]};
        // After the MSB step c holds carry_out; undo overflow to get the true sign
        less    = sum_msb ^ cin_msb ^ c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ash      <= '0;
            bsh      <= '0;
            op_r     <= '0;
            cnt      <= '0;
            c        <= 1'b0;
            cin_msb  <= 1'b0;
            sum_msb  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            sel      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        ash   <= a;
                        bsh   <= b;
                        op_r  <= op;
                        c     <= op[2];
                        sel   <= sel_of(op);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    ash    <= ash >> 1;
                    bsh    <= bsh >> 1;
                    c      <= cout;
                    result <= shifted;
                    if (cnt == LAST) begin
                        cin_msb  <= c;
                        sum_msb  <= sum;
                        overflow <= (op_r == OP_ADD || op_r == OP_SUB) ? (c ^ cout) : 1'b0;
                        if (op_r == OP_SLT) begin
                            sel   <= 2'b11;
                            state <= FIX;
                        end else begin
                            sel   <= 2'b00;
                            zero  <= (shifted == '0);
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    result   <= {{(WIDTH-1){1'b0}}, less};
                    overflow <= 1'b0;
                    zero     <= ~less;
                    sel      <= 2'b00;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
